// File: rtl/fifo_unpacker.sv
// Read-side consumer for a show-ahead wide FIFO: pops one entry and emits it as
// LSB-first OUT_WIDTH beats on a valid/ready stream, chaining entries without bubbles.
module fifo_unpacker #(
    parameter int WIDTH     = 248,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     i_fifo_data,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_read,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_last,
    output logic [$clog2((WIDTH+OUT_WIDTH-1)/OUT_WIDTH):0] o_beat_idx,
    output logic                 o_busy
);

    localparam int NUM_BEATS = (WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int IDX_W     = $clog2(NUM_BEATS) + 1;
    localparam int SEL_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int PAD_W     = NUM_BEATS * OUT_WIDTH;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                              r_state;
    logic [NUM_BEATS-1:0][OUT_WIDTH-1:0] r_entry;
    logic [IDX_W-1:0]                    r_beat;
    logic                                r_valid;
    logic                                r_last;

    logic [PAD_W-1:0] w_padded;
    logic             w_at_last;
    logic             w_hs;
    logic             w_pop;

    // Bits above WIDTH-1 in the final beat are held as zero in the entry register.
    always_comb begin
        w_padded              = '0;
        w_padded[WIDTH-1:0]   = i_fifo_data;
    end

    assign w_at_last = (r_beat == LAST_BEAT);
    assign w_hs      = r_valid && i_ready;
    assign w_pop     = !rst && !i_fifo_empty &&
                       ((r_state == IDLE) || (w_hs && w_at_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_entry <= '0;
            r_beat  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_pop) begin
            r_state <= SEND;
            r_entry <= w_padded;
            r_beat  <= '0;
            r_valid <= 1'b1;
            r_last  <= (NUM_BEATS == 1);
        end else if (w_hs) begin
            if (w_at_last) begin
                r_state <= IDLE;
                r_beat  <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_beat  <= r_beat + IDX_W'(1);
                r_last  <= ((r_beat + IDX_W'(1)) == LAST_BEAT);
            end
        end
    end

    assign o_fifo_read = w_pop;
    assign o_valid     = r_valid;
    assign o_data      = r_entry[r_beat[SEL_W-1:0]];
    assign o_last      = r_last;
    assign o_beat_idx  = r_beat;
    assign o_busy      = (r_state == SEND);

endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: default 248->32 instance plus a one-beat 248->248 instance,
// both checked every cycle against a queue-based beat scoreboard.
module tb_fifo_unpacker;

    localparam int W  = 248;
    localparam int OW = 32;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  fdata, fdata2;
    logic          fempty, fempty2, fread, fread2;
    logic          valid, valid2, ready, ready2, last, last2, busy, busy2;
    logic [OW-1:0] data;
    logic [W-1:0]  data2;
    logic [3:0]    idx;
    logic [0:0]    idx2;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  src[$], src2[$], pend2[$];
    logic [OW-1:0] pend[$];

    always #5 clk = ~clk;

    fifo_unpacker #(.WIDTH(W), .OUT_WIDTH(OW)) u_dut (
        .clk(clk), .rst(rst), .i_fifo_data(fdata), .i_fifo_empty(fempty),
        .o_fifo_read(fread), .o_valid(valid), .i_ready(ready), .o_data(data),
        .o_last(last), .o_beat_idx(idx), .o_busy(busy)
    );

    fifo_unpacker #(.WIDTH(W), .OUT_WIDTH(W)) u_wide (
        .clk(clk), .rst(rst), .i_fifo_data(fdata2), .i_fifo_empty(fempty2),
        .o_fifo_read(fread2), .o_valid(valid2), .i_ready(ready2), .o_data(data2),
        .o_last(last2), .o_beat_idx(idx2), .o_busy(busy2)
    );

    function automatic logic [W-1:0] rand_entry();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    function automatic logic [OW-1:0] slice_of(logic [W-1:0] e, int k);
        logic [NB*OW-1:0] t;
        t = {{(NB*OW-W){1'b0}}, e} >> (k * OW);
        return t[OW-1:0];
    endfunction

    // Pop rule: source non-empty and either nothing pending or the last pending beat is being taken.
    function automatic logic exp_pop();
        return !rst && src.size() > 0 && (pend.size() == 0 || (ready && pend.size() == 1));
    endfunction

    function automatic logic exp_pop2();
        return !rst && src2.size() > 0 && (pend2.size() == 0 || ready2);
    endfunction

    function automatic logic [39:0] exp_vec();
        logic [39:0] r;
        r = '0;
        r[39] = exp_pop();
        if (pend.size() > 0) begin
            r[38] = 1'b1;
            r[37] = 1'b1;
            r[36] = (pend.size() == 1);
            r[35:32] = 4'(NB - pend.size());
            r[31:0] = pend[0];
        end
        return r;
    endfunction

    function automatic logic [39:0] obs_vec();
        logic [39:0] r;
        r = '0;
        r[39] = fread;
        r[38] = valid;
        r[37] = busy;
        if (valid !== 1'b0) r[36:0] = {last, idx, data};
        return r;
    endfunction

    function automatic logic [252:0] exp_vec2();
        logic [252:0] r;
        r = '0;
        r[252] = exp_pop2();
        if (pend2.size() > 0) r[251:0] = {1'b1, 1'b1, 1'b1, 1'b0, pend2[0]};
        return r;
    endfunction

    function automatic logic [252:0] obs_vec2();
        logic [252:0] r;
        r = '0;
        r[252] = fread2;
        r[251] = valid2;
        r[250] = busy2;
        if (valid2 !== 1'b0) r[249:0] = {last2, idx2, data2};
        return r;
    endfunction

    task automatic drive();
        fempty  = (src.size() == 0);
        fdata   = fempty ? '0 : src[0];
        fempty2 = (src2.size() == 0);
        fdata2  = fempty2 ? '0 : src2[0];
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    // Advance one clock and update the scoreboard from the model's own predictions.
    task automatic cycle();
        logic p, h, p2, h2;
        logic [W-1:0] e;
        p  = exp_pop();
        h  = pend.size() > 0 && ready;
        p2 = exp_pop2();
        h2 = pend2.size() > 0 && ready2;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            pend2.delete();
        end else begin
            if (h) void'(pend.pop_front());
            if (p) begin
                e = src.pop_front();
                for (int k = 0; k < NB; k++) pend.push_back(slice_of(e, k));
            end
            if (h2) void'(pend2.pop_front());
            if (p2) pend2.push_back(src2.pop_front());
        end
        #1;
        drive();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b1; ready2 = 1'b1;
        src.push_back(rand_entry());
        src2.push_back(rand_entry());
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        settle();
        checks++;
        if ({fread, valid, last, idx, data, busy} !== '0) begin
            failures++;
            $display("FAIL reset_main got={rd%b v%b l%b i%0d d%h b%b} want=all zero", fread, valid, last, idx, data, busy);
        end
        checks++;
        if ({fread2, valid2, last2, idx2, busy2} !== '0) begin
            failures++;
            $display("FAIL reset_wide got={rd%b v%b l%b i%0d b%b} want=all zero", fread2, valid2, last2, idx2, busy2);
        end
        src.delete(); src2.delete();
        drive();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_single();
        logic [W-1:0] e;
        int n_pop = 0;
        logic [OW-1:0] b0 = '0, b7 = '0;
        for (int i = 0; i < 31; i++) e[i*8 +: 8] = 8'(i + 1);
        src.push_back(e);
        ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (fread) n_pop++;
            if (valid && idx == 0) b0 = data;
            if (valid && last) b7 = data;
            cycle();
        end
        checks++;
        if (n_pop != 1) begin failures++; $display("FAIL single_pops got=%0d want=1", n_pop); end
        checks++;
        if (b0 !== 32'h04030201) begin failures++; $display("FAIL single_beat0 got=%h want=04030201", b0); end
        checks++;
        if (b7 !== 32'h001F1E1D) begin failures++; $display("FAIL single_beat7 got=%h want=001f1e1d", b7); end
    endtask

    task automatic test_back_to_back();
        int n_pop = 0, n_val = 0, first_v = -1, last_v = -1;
        repeat (3) src.push_back(rand_entry());
        ready = 1'b1;
        for (int c = 0; c < 28; c++) begin
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (fread) n_pop++;
            if (valid) begin
                n_val++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            cycle();
        end
        checks++;
        if (n_pop != 3 || n_val != 24 || last_v - first_v + 1 != 24) begin
            failures++;
            $display("FAIL b2b_stream got pops=%0d valid=%0d span=%0d want pops=3 valid=24 span=24",
                     n_pop, n_val, last_v - first_v + 1);
        end
    endtask

    task automatic test_backpressure();
        int n_hs = 0;
        logic stalled = 1'b0;
        logic [OW-1:0] pd = '0;
        logic [3:0] pi = '0;
        src.push_back(rand_entry());
        for (int c = 0; c < 60 && (src.size() > 0 || pend.size() > 0); c++) begin
            ready = (c % 3 == 0);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL bp c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (stalled && valid) begin
                checks++;
                if (data !== pd || idx !== pi) begin
                    failures++;
                    $display("FAIL bp_stable c=%0d got d=%h i=%0d want d=%h i=%0d", c, data, idx, pd, pi);
                end
            end
            stalled = valid && !ready;
            pd = data; pi = idx;
            if (valid && ready) n_hs++;
            cycle();
        end
        checks++;
        if (n_hs != 8 || pend.size() != 0) begin
            failures++;
            $display("FAIL bp_beats got=%0d left=%0d want=8 left=0", n_hs, pend.size());
        end
        ready = 1'b1;
    endtask

    task automatic test_empty();
        for (int c = 0; c < 20; c++) begin
            settle();
            checks++;
            if (fread !== 1'b0 || valid !== 1'b0) begin
                failures++;
                $display("FAIL empty c=%0d got rd=%b v=%b want rd=0 v=0", c, fread, valid);
            end
            cycle();
        end
        src.push_back(rand_entry());
        settle();
        checks++;
        if (fread !== 1'b1) begin failures++; $display("FAIL empty_first_pop got=%b want=1", fread); end
        for (int c = 0; c < 15; c++) begin
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL empty_drain c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        repeat (2) src.push_back(rand_entry());
        ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rmid c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (valid && idx == 3) found = 1'b1;
            else cycle();
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rmid_reach_beat3 got=timeout want=beat 3"); end
        rst = 1'b1;
        settle();
        checks++;
        if (fread !== 1'b0) begin failures++; $display("FAIL rmid_pop_in_rst got=%b want=0", fread); end
        cycle();
        rst = 1'b0;
        settle();
        checks++;
        if ({valid, idx, busy, last} !== '0) begin
            failures++;
            $display("FAIL rmid_after got v=%b i=%0d b=%b l=%b want all 0", valid, idx, busy, last);
        end
        for (int c = 0; c < 20; c++) begin
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rmid_resume c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0 && src.size() < 4) src.push_back(rand_entry());
            if ($urandom_range(3) == 0 && src2.size() < 4) src2.push_back(rand_entry());
            ready  = ($urandom_range(9) < 6);
            ready2 = ($urandom_range(9) < 6);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rand c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (obs_vec2() !== exp_vec2()) begin
                failures++;
                $display("FAIL rand_wide c=%0d got=%h want=%h", c, obs_vec2(), exp_vec2());
            end
            cycle();
        end
        ready = 1'b1; ready2 = 1'b1;
        for (int c = 0; c < 80 && (src.size() + pend.size() + src2.size() + pend2.size() > 0); c++) cycle();
        checks++;
        if (src.size() + pend.size() + src2.size() + pend2.size() != 0) begin
            failures++;
            $display("FAIL rand_drain got=timeout want=drained");
        end
    endtask

    task automatic test_wide();
        int n_pop = 0;
        repeat (14) src2.push_back(rand_entry());
        ready2 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            settle();
            checks++;
            if (obs_vec2() !== exp_vec2()) begin
                failures++;
                $display("FAIL wide c=%0d got=%h want=%h", c, obs_vec2(), exp_vec2());
            end
            if (c < 12 && fread2) n_pop++;
            if (valid2) begin
                checks++;
                if (last2 !== 1'b1) begin failures++; $display("FAIL wide_last c=%0d got=%b want=1", c, last2); end
            end
            cycle();
        end
        checks++;
        if (n_pop != 12) begin failures++; $display("FAIL wide_rate got=%0d want=12", n_pop); end
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; ready2 = 1'b0;
        drive();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_empty();
        test_reset_mid();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=stuck want=finished");
        $fatal(1, "timeout");
    end

endmodule
